// File: rtl/bg_mosaic_hold_pkg.sv
// Shared pixel type and constants for the BG mosaic hold stage.
package bg_mosaic_hold_pkg;

  localparam int unsigned BG_PIX_W = 13;

  typedef struct packed {
    logic       opaque;
    logic       prio;
    logic [2:0] pal;
    logic [7:0] color;
  } bg_pix_t;

  localparam bg_pix_t    BG_PIX_ZERO = '0;
  localparam logic [4:0] GAP_MAX     = 5'h1F;

endpackage

// File: rtl/bg_mosaic_hold_if.sv
// Mosaic interface bundle between the BG units/controller and the mosaic hold stage.
interface bg_mosaic_hold_if #(
  parameter int unsigned NUM_BG = 4,
  parameter int unsigned PIX_W  = 13
) ();

  logic                    dot_en;
  logic                    period_start;
  logic                    pixel_strobe;
  logic [3:0]              size;
  logic [NUM_BG-1:0]       enable_mask;
  logic [NUM_BG*PIX_W-1:0] bg_pix_in;
  logic [NUM_BG*PIX_W-1:0] bg_pix_out;
  logic                    strobe_err;

  modport master (
    output dot_en, period_start, pixel_strobe, size, enable_mask, bg_pix_in,
    input  bg_pix_out, strobe_err
  );

  modport slave (
    input  dot_en, period_start, pixel_strobe, size, enable_mask, bg_pix_in,
    output bg_pix_out, strobe_err
  );

endinterface

// File: rtl/bg_mosaic_hold_lane.sv
// One BG layer: captures the pixel at block start and replays it until the next strobe.
module bg_mosaic_hold_lane
  import bg_mosaic_hold_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    dot_en_i,
  input  logic    active_i,
  input  logic    strobe_i,
  input  bg_pix_t pix_i,
  output bg_pix_t pix_o
);

  bg_pix_t held_q, held_d;
  bg_pix_t out_q, out_d;

  always_comb begin
    held_d = held_q;
    out_d  = out_q;
    if (dot_en_i) begin
      if (!active_i || strobe_i) begin
        held_d = pix_i;
        out_d  = pix_i;
      end else begin
        out_d = held_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q <= BG_PIX_ZERO;
      out_q  <= BG_PIX_ZERO;
    end else begin
      held_q <= held_d;
      out_q  <= out_d;
    end
  end

  assign pix_o = out_q;

endmodule

// File: rtl/bg_mosaic_hold.sv
// Horizontal mosaic hold for all BG layers: per-line mask/size latch, lanes, strobe watchdog.
module bg_mosaic_hold
  import bg_mosaic_hold_pkg::*;
#(
  parameter int unsigned NUM_BG = 4,
  parameter int unsigned PIX_W  = BG_PIX_W
) (
  input  logic clk,
  input  logic reset,
  bg_mosaic_hold_if.slave bus
);

  logic [NUM_BG-1:0] act_mask_q, act_mask_d;
  logic [3:0]        act_size_q, act_size_d;
  logic [4:0]        gap_ctr_q, gap_ctr_d;
  logic              strobe_err_q, strobe_err_d;

  logic [NUM_BG-1:0] eff_mask;
  logic [3:0]        eff_size;
  logic [NUM_BG-1:0] lane_active;
  logic              any_active;

  // A period_start dot already uses the freshly written $2106 values.
  always_comb begin
    eff_mask    = bus.period_start ? bus.enable_mask : act_mask_q;
    eff_size    = bus.period_start ? bus.size : act_size_q;
    lane_active = (eff_size != 4'd0) ? eff_mask : '0;
    any_active  = |lane_active;
  end

  always_comb begin
    act_mask_d   = act_mask_q;
    act_size_d   = act_size_q;
    gap_ctr_d    = gap_ctr_q;
    strobe_err_d = strobe_err_q;
    if (bus.dot_en) begin
      if (bus.period_start) begin
        act_mask_d = bus.enable_mask;
        act_size_d = bus.size;
      end
      if (!any_active || bus.period_start || bus.pixel_strobe) begin
        gap_ctr_d = 5'd0;
      end else if (gap_ctr_q != GAP_MAX) begin
        gap_ctr_d = gap_ctr_q + 5'd1;
      end
      // Block ran past size+1 dots with no strobe from the mosaic controller.
      if (any_active && !bus.period_start && !bus.pixel_strobe &&
          (gap_ctr_q > {1'b0, eff_size})) begin
        strobe_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_mask_q   <= '0;
      act_size_q   <= 4'd0;
      gap_ctr_q    <= 5'd0;
      strobe_err_q <= 1'b0;
    end else begin
      act_mask_q   <= act_mask_d;
      act_size_q   <= act_size_d;
      gap_ctr_q    <= gap_ctr_d;
      strobe_err_q <= strobe_err_d;
    end
  end

  bg_pix_t lane_out [NUM_BG];

  for (genvar n = 0; n < NUM_BG; n++) begin : g_lane
    bg_mosaic_hold_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .dot_en_i (bus.dot_en),
      .active_i (lane_active[n]),
      .strobe_i (bus.pixel_strobe),
      .pix_i    (bus.bg_pix_in[n*PIX_W +: PIX_W]),
      .pix_o    (lane_out[n])
    );
    assign bus.bg_pix_out[n*PIX_W +: PIX_W] = lane_out[n];
  end

  assign bus.strobe_err = strobe_err_q;

endmodule
